// File: rtl/servo_pkg.sv
// Shared constants for the servo PWM channel: angle codes, FSM encoding and
// 25 MHz timing defaults.
package servo_pkg;

    localparam logic [3:0] ANG_HOLD    = 4'd0;
    localparam logic [3:0] ANG_NEG     = 4'd1;
    localparam logic [3:0] ANG_POS     = 4'd2;
    localparam logic [3:0] ANG_RELEASE = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_CLKS_PER_FRAME = 500000;
    localparam int DEF_CNT_W          = 20;
    localparam int DEF_MIN_W          = 25000;
    localparam int DEF_MAX_W          = 50000;
    localparam int DEF_CENTER_W       = 37500;
    localparam int DEF_STEP_W         = 250;
    localparam int DEF_PARK_W         = 25000;
    localparam int DEF_ACTIVE_W       = 50000;

    // Absolute-mode channels power up parked; incremental ones start centred.
    function automatic int reset_width(input int mode, input int center_w, input int park_w);
        return (mode == 1) ? park_w : center_w;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame counter for one servo channel: counts 0..CLKS_PER_FRAME-1 while running,
// flags the last cycle of the frame and the first cycle of each running frame.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int CLKS_PER_FRAME = DEF_CLKS_PER_FRAME,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Run,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Wrap,
    output logic             o_Frame_Start
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_FRAME - 1);

    // NOTE: non-blocking assignments on every flop so all registers sample pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Count <= '0;
        end else if (!i_Run || o_Wrap) begin
            o_Count <= '0;
        end else begin
            o_Count <= o_Count + 1'b1;
        end
    end

    assign o_Wrap        = i_Run && (o_Count == LAST);
    assign o_Frame_Start = i_Run && (o_Count == '0);

endmodule

// File: rtl/servo_pwm_channel.sv
// One hobby-servo PWM channel: frame FSM, per-frame width update from the angle
// code, and the registered pulse output.
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int CLKS_PER_FRAME = DEF_CLKS_PER_FRAME,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int MIN_W          = DEF_MIN_W,
    parameter int MAX_W          = DEF_MAX_W,
    parameter int CENTER_W       = DEF_CENTER_W,
    parameter int STEP_W         = DEF_STEP_W,
    parameter int MODE           = 0,
    parameter int PARK_W         = DEF_PARK_W,
    parameter int ACTIVE_W       = DEF_ACTIVE_W
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Enable,
    input  logic [3:0]       i_Angle,
    output logic             o_PWM,
    output logic [CNT_W-1:0] o_Width,
    output logic             o_Frame_Start,
    output logic             o_At_Min,
    output logic             o_At_Max
);

    localparam logic [CNT_W-1:0] RST_W    = CNT_W'(reset_width(MODE, CENTER_W, PARK_W));
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] PARK_C   = CNT_W'(PARK_W);
    localparam logic [CNT_W-1:0] ACTIVE_C = CNT_W'(ACTIVE_W);
    localparam logic [CNT_W:0]   MIN_X    = (CNT_W+1)'(MIN_W);
    localparam logic [CNT_W:0]   MAX_X    = (CNT_W+1)'(MAX_W);
    localparam logic [CNT_W:0]   STEP_X   = (CNT_W+1)'(STEP_W);

    state_t           state;
    state_t           state_nxt;
    logic             run;
    logic             upd;
    logic [CNT_W-1:0] count;
    logic             wrap;
    logic [3:0]       code_q;
    logic [CNT_W-1:0] width_next;
    logic [CNT_W-1:0] width_calc;
    logic [CNT_W:0]   w_dec;
    logic [CNT_W:0]   w_inc;

    servo_frame_timer #(
        .CLKS_PER_FRAME (CLKS_PER_FRAME),
        .CNT_W          (CNT_W)
    ) u_timer (
        .i_Clk         (i_Clk),
        .i_Rst_n       (i_Rst_n),
        .i_Run         (run),
        .o_Count       (count),
        .o_Wrap        (wrap),
        .o_Frame_Start (o_Frame_Start)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_Enable) state_nxt = ST_RUN;
            ST_RUN:   if (!i_Enable) state_nxt = wrap ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (wrap) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        run = (state != ST_IDLE);
        upd = (state == ST_RUN) && wrap;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) code_q <= ANG_HOLD;
        else          code_q <= i_Angle;
    end

    // One extra bit exposes the borrow/carry so clamping never sees a wrapped value.
    assign w_dec = {1'b0, o_Width} - STEP_X;
    assign w_inc = {1'b0, o_Width} + STEP_X;

    always_comb begin
        width_calc = o_Width;
        if (MODE == 1) begin
            width_calc = (code_q == ANG_NEG) ? ACTIVE_C : PARK_C;
        end else begin
            case (code_q)
                ANG_NEG: width_calc = (w_dec[CNT_W] || (w_dec < MIN_X)) ? MIN_C : w_dec[CNT_W-1:0];
                ANG_POS: width_calc = (w_inc > MAX_X) ? MAX_C : w_inc[CNT_W-1:0];
                default: width_calc = o_Width;
            endcase
        end
    end

    // o_Width takes the new value at the end of counter 0; the pulse is high for
    // counter 0 under any legal width, so the whole frame follows the new width.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            width_next <= RST_W;
            o_Width    <= RST_W;
        end else begin
            if (upd)           width_next <= width_calc;
            if (o_Frame_Start) o_Width    <= width_next;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) o_PWM <= 1'b0;
        else          o_PWM <= run && (count < o_Width);
    end

    assign o_At_Min = (o_Width == MIN_C);
    assign o_At_Max = (o_Width == MAX_C);

endmodule

// File: tb/tb_servo_pwm_channel.sv
// Directed bench for servo_pwm_channel: one incremental and one absolute channel
// with a 100-clock frame and 10..20 clock pulse widths.
module tb_servo_pwm_channel;

    localparam int FRAME = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en0 = 1'b0, en1 = 1'b0;
    logic [3:0]  ang0 = 4'd0, ang1 = 4'd0;
    logic        pwm0, pwm1, fs0, fs1, min0, min1, max0, max1;
    logic [19:0] w0, w1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    servo_pwm_channel #(
        .CLKS_PER_FRAME(100), .CNT_W(20), .MIN_W(10), .MAX_W(20), .CENTER_W(15),
        .STEP_W(2), .MODE(0), .PARK_W(10), .ACTIVE_W(20)
    ) u_dut0 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en0), .i_Angle(ang0),
        .o_PWM(pwm0), .o_Width(w0), .o_Frame_Start(fs0), .o_At_Min(min0), .o_At_Max(max0)
    );

    servo_pwm_channel #(
        .CLKS_PER_FRAME(100), .CNT_W(20), .MIN_W(10), .MAX_W(20), .CENTER_W(15),
        .STEP_W(2), .MODE(1), .PARK_W(10), .ACTIVE_W(20)
    ) u_dut1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en1), .i_Angle(ang1),
        .o_PWM(pwm1), .o_Width(w1), .o_Frame_Start(fs1), .o_At_Min(min1), .o_At_Max(max1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns at the negedge where the selected channel shows o_Frame_Start.
    task automatic wait_fs(input bit sel, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? fs1 : fs0) && n < 300);
        check({tag, "_fs_seen"}, 32'(sel ? fs1 : fs0), 1);
    endtask

    // Called at the negedge of counter 0; observes counters 1..99 and the next counter 0.
    task automatic measure(input bit sel, input int chg_at, input logic [3:0] chg_val,
                           input int drop_at, output int hi, output int w_mid,
                           output bit mn, output bit mx, output bit fs_end, output int fs_mid);
        hi = 0; w_mid = 0; mn = 0; mx = 0; fs_end = 0; fs_mid = 0;
        for (int i = 1; i <= FRAME; i++) begin
            @(negedge clk);
            if (i == chg_at) begin
                if (sel) ang1 = chg_val;
                else     ang0 = chg_val;
            end
            if (i == drop_at) begin
                if (sel) en1 = 1'b0;
                else     en0 = 1'b0;
            end
            if (sel ? pwm1 : pwm0) hi++;
            if (i == 50) begin
                w_mid = int'(sel ? w1 : w0);
                mn    = sel ? min1 : min0;
                mx    = sel ? max1 : max0;
            end
            if (i < FRAME && (sel ? fs1 : fs0)) fs_mid++;
            if (i == FRAME) fs_end = sel ? fs1 : fs0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi, wm, fsm, idle_hi, idle_fs;
        bit mn, mx, fse;
        int up_w[4]  = '{17, 19, 20, 20};
        bit up_mx[4] = '{0, 0, 1, 1};
        int dn_w[5]  = '{15, 13, 11, 10, 10};
        bit dn_mn[5] = '{0, 0, 0, 1, 1};
        logic [3:0] abs_ang[8] = '{4'd1, 4'd2, 4'd1, 4'd5, 4'd1, 4'd15, 4'd0, 4'd1};
        int abs_w[8] = '{10, 20, 10, 20, 10, 20, 10, 10};

        repeat (3) @(negedge clk);
        check("rst_pwm0", 32'(pwm0), 0);
        check("rst_w0", 32'(w0), 15);
        check("rst_fs0", 32'(fs0), 0);
        check("rst_min0", 32'(min0), 0);
        check("rst_max0", 32'(max0), 0);
        check("rst_w1", 32'(w1), 10);
        check("rst_min1", 32'(min1), 1);
        check("rst_max1", 32'(max1), 0);
        rst_n = 1'b1;

        // Basic frame at centre width
        @(negedge clk);
        en0 = 1'b1;
        wait_fs(0, "s1");
        measure(0, -1, 4'd0, -1, hi, wm, mn, mx, fse, fsm);
        check("s1_hi", 32'(hi), 15);
        check("s1_w", 32'(wm), 15);
        check("s1_fs_period", 32'(fse), 1);
        check("s1_fs_mid", 32'(fsm), 0);

        // Step positive: current frame unchanged, then 17,19,20,20
        ang0 = 4'd2;
        measure(0, -1, 4'd0, -1, hi, wm, mn, mx, fse, fsm);
        check("s2_first_hi", 32'(hi), 15);
        for (int k = 0; k < 4; k++) begin
            measure(0, -1, 4'd0, -1, hi, wm, mn, mx, fse, fsm);
            check($sformatf("s2_hi%0d", k), 32'(hi), 32'(up_w[k]));
            check($sformatf("s2_w%0d", k), 32'(wm), 32'(up_w[k]));
            check($sformatf("s2_max%0d", k), 32'(mx), 32'(up_mx[k]));
        end

        // Reset restores centre, then step negative down to the floor
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("s3_rst_w", 32'(w0), 15);
        ang0 = 4'd1;
        en0  = 1'b1;
        wait_fs(0, "s3");
        for (int k = 0; k < 5; k++) begin
            measure(0, -1, 4'd0, -1, hi, wm, mn, mx, fse, fsm);
            check($sformatf("s3_hi%0d", k), 32'(hi), 32'(dn_w[k]));
            check($sformatf("s3_w%0d", k), 32'(wm), 32'(dn_w[k]));
            check($sformatf("s3_min%0d", k), 32'(mn), 32'(dn_mn[k]));
        end

        // Code change mid-frame only affects the following frame
        measure(0, 40, 4'd2, -1, hi, wm, mn, mx, fse, fsm);
        check("s4_cur_hi", 32'(hi), 10);
        check("s4_cur_w", 32'(wm), 10);
        measure(0, 1, 4'd0, -1, hi, wm, mn, mx, fse, fsm);
        check("s4_next_hi", 32'(hi), 12);
        check("s4_next_w", 32'(wm), 12);

        // Enable dropped at counter 5: frame completes, then idle
        measure(0, -1, 4'd0, 5, hi, wm, mn, mx, fse, fsm);
        check("s5_drain_hi", 32'(hi), 12);
        check("s5_drain_fs_end", 32'(fse), 0);
        check("s5_drain_fs_mid", 32'(fsm), 0);
        idle_hi = 0;
        idle_fs = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (pwm0) idle_hi++;
            if (fs0)  idle_fs++;
        end
        check("s5_idle_pwm", 32'(idle_hi), 0);
        check("s5_idle_fs", 32'(idle_fs), 0);
        check("s5_idle_w", 32'(w0), 12);
        en0 = 1'b1;
        wait_fs(0, "s5");
        measure(0, -1, 4'd0, -1, hi, wm, mn, mx, fse, fsm);
        check("s5_resume_hi", 32'(hi), 12);
        check("s5_resume_w", 32'(wm), 12);
        check("s5_resume_fs", 32'(fse), 1);

        // Absolute mode: code 1 -> active width, anything else -> park
        ang1 = 4'd1;
        en1  = 1'b1;
        wait_fs(1, "s6");
        for (int k = 0; k < 8; k++) begin
            ang1 = abs_ang[k];
            measure(1, -1, 4'd0, -1, hi, wm, mn, mx, fse, fsm);
            check($sformatf("s6_hi%0d", k), 32'(hi), 32'(abs_w[k]));
            check($sformatf("s6_w%0d", k), 32'(wm), 32'(abs_w[k]));
            check($sformatf("s6_max%0d", k), 32'(mx), 32'(abs_w[k] == 20));
        end

        // Reset in the middle of an active-width pulse
        ang1 = 4'd0;
        repeat (3) @(negedge clk);
        check("s7_pre_pwm", 32'(pwm1), 1);
        check("s7_pre_w", 32'(w1), 20);
        #2;
        rst_n = 1'b0;
        #1;
        check("s7_rst_pwm", 32'(pwm1), 0);
        check("s7_rst_w", 32'(w1), 10);
        check("s7_rst_min", 32'(min1), 1);
        check("s7_rst_w0", 32'(w0), 15);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_fs(1, "s7");
        measure(1, -1, 4'd0, -1, hi, wm, mn, mx, fse, fsm);
        check("s7_fresh_hi", 32'(hi), 10);
        check("s7_fresh_fs", 32'(fse), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
